// File: rtl/hazard_ctrl_gen2_if.sv
// hazard_ctrl_gen2_if
//   Bundles every pipeline-facing signal of the hazard controller.
//   slave  : the hazard controller side (status in, controls out).
//   master : the pipeline / datapath side (status out, controls in).
//
//   Status (pipeline -> controller):
//     ihit, dhit            memory hit strobes
//     dmemREN, dmemWEN      outstanding data-memory request
//     halt_wb               HALT opcode in WB
//     opcode_if_id, func_if_id, rs_if_id, rt_if_id   decode-stage fields
//     rt_id_ex, dren_id_ex  execute-stage load destination / load flag
//     opcode_ex_mem, zero_ex_mem                     resolving branch
//   Controls (controller -> pipeline):
//     pcsrc                 PC mux select
//     enable_*, flush_*     pipeline latch enables / synchronous clears
//     halted                sticky halt indicator
//     stall_cnt, flush_cnt  performance counters
interface hazard_ctrl_gen2_if #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
);
  logic              ihit;
  logic              dhit;
  logic              dmemREN;
  logic              dmemWEN;
  logic              halt_wb;
  logic [5:0]        opcode_if_id;
  logic [5:0]        func_if_id;
  logic [REG_AW-1:0] rs_if_id;
  logic [REG_AW-1:0] rt_if_id;
  logic [REG_AW-1:0] rt_id_ex;
  logic              dren_id_ex;
  logic [5:0]        opcode_ex_mem;
  logic              zero_ex_mem;

  logic [2:0]        pcsrc;
  logic              enable_pc;
  logic              enable_if_id;
  logic              enable_id_ex;
  logic              enable_ex_mem;
  logic              enable_mem_wb;
  logic              flush_if_id;
  logic              flush_id_ex;
  logic              flush_ex_mem;
  logic              flush_mem_wb;
  logic              halted;
  logic [CNT_W-1:0]  stall_cnt;
  logic [CNT_W-1:0]  flush_cnt;

  modport slave (
    input  ihit, dhit, dmemREN, dmemWEN, halt_wb,
           opcode_if_id, func_if_id, rs_if_id, rt_if_id,
           rt_id_ex, dren_id_ex, opcode_ex_mem, zero_ex_mem,
    output pcsrc, enable_pc, enable_if_id, enable_id_ex, enable_ex_mem,
           enable_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem,
           flush_mem_wb, halted, stall_cnt, flush_cnt
  );

  modport master (
    output ihit, dhit, dmemREN, dmemWEN, halt_wb,
           opcode_if_id, func_if_id, rs_if_id, rt_if_id,
           rt_id_ex, dren_id_ex, opcode_ex_mem, zero_ex_mem,
    input  pcsrc, enable_pc, enable_if_id, enable_id_ex, enable_ex_mem,
           enable_mem_wb, flush_if_id, flush_id_ex, flush_ex_mem,
           flush_mem_wb, halted, stall_cnt, flush_cnt
  );
endinterface

// File: rtl/hazard_ctrl_gen2.sv
// hazard_ctrl_gen2
//   Hazard controller for the 5-stage MIPS pipeline. Generates latch
//   enables/flushes and the PC source select. Branches are predicted taken
//   in IF/ID and resolved in EX/MEM; J/JAL/JR redirect from IF/ID. A load-use
//   hazard inserts LD_USE_STALLS bubbles (1..3), a HALT in WB freezes the
//   pipeline until reset.
//
//   Ports:
//     CLK   pipeline clock, rising edge
//     nRST  asynchronous active-low reset
//     hz    hazard_ctrl_gen2_if.slave (all status inputs / control outputs)
//
//   Parameters: LD_USE_STALLS (1..3), REG_AW (register index width),
//               CNT_W (performance counter width).
//
//   Build option: define HAZARD_PERF_CNT_EN to build the saturating
//   stall_cnt / flush_cnt counters; otherwise both read 0.
module hazard_ctrl_gen2 #(
  parameter int unsigned LD_USE_STALLS = 1,
  parameter int unsigned REG_AW        = 5,
  parameter int unsigned CNT_W         = 32
) (
  input logic              CLK,
  input logic              nRST,
  hazard_ctrl_gen2_if.slave hz
);

  // PC mux encodings (data_path_muxs_pkg values)
  localparam logic [2:0] SEL_LOAD_NXT_INSTR     = 3'd0;
  localparam logic [2:0] SEL_LOAD_BR_ADDR       = 3'd1;
  localparam logic [2:0] SEL_LOAD_NXT_PC_EX_MEM = 3'd2;
  localparam logic [2:0] SEL_LOAD_JMP_ADDR      = 3'd3;
  localparam logic [2:0] SEL_LOAD_JR_ADDR       = 3'd4;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FUNC_JR  = 6'h08;

  typedef enum logic [1:0] {IDLE, LD_STALL, HALTED} state_t;

  state_t     state_q, state_d;
  logic [1:0] rem_q, rem_d;   // bubbles still owed after the detection cycle

  logic move;
  logic halt_act;
  logic mispredict;
  logic ld_use_det;
  logic rule_freeze;
  logic rule_mispredict;
  logic rule_ld_use;

  assign move = hz.ihit & ~((hz.dmemREN | hz.dmemWEN) & ~hz.dhit) & ~hz.halt_wb;

  // halt_wb takes effect in the same cycle it is seen, not only once latched
  assign halt_act = (state_q == HALTED) | hz.halt_wb;

  assign mispredict = ((hz.opcode_ex_mem == OP_BEQ) & ~hz.zero_ex_mem) |
                      ((hz.opcode_ex_mem == OP_BNE) &  hz.zero_ex_mem);

  // A load into $zero never creates a real dependency
  assign ld_use_det = hz.dren_id_ex & (hz.rt_id_ex != REG_AW'(0)) &
                      ((hz.rt_id_ex == hz.rs_if_id) | (hz.rt_id_ex == hz.rt_if_id));

  // Priority-resolved rule activity, shared by the output logic and counters
  assign rule_freeze     = ~halt_act & ~move;
  assign rule_mispredict = ~halt_act & move & mispredict;
  assign rule_ld_use     = ~halt_act & move & ~mispredict &
                           ((state_q == LD_STALL) | ((state_q == IDLE) & ld_use_det));

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, regardless of process evaluation order.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q <= IDLE;
      rem_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
    end
  end

  // NOTE: every variable driven here gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    hz.pcsrc         = SEL_LOAD_NXT_INSTR;
    hz.enable_pc     = move;
    hz.enable_if_id  = move;
    hz.enable_id_ex  = move;
    hz.enable_ex_mem = move;
    hz.enable_mem_wb = move;
    hz.flush_if_id   = 1'b0;
    hz.flush_id_ex   = 1'b0;
    hz.flush_ex_mem  = 1'b0;
    hz.flush_mem_wb  = 1'b0;
    hz.halted        = halt_act;
    state_d          = state_q;
    rem_d            = rem_q;

    if (halt_act) begin
      // HALTED may coexist with ihit=1, so move alone does not stop it
      hz.enable_pc     = 1'b0;
      hz.enable_if_id  = 1'b0;
      hz.enable_id_ex  = 1'b0;
      hz.enable_ex_mem = 1'b0;
      hz.enable_mem_wb = 1'b0;
      state_d          = HALTED;
    end else if (rule_freeze) begin
      // enables already 0 via move; state and remaining count hold
    end else if (rule_mispredict) begin
      hz.pcsrc        = SEL_LOAD_NXT_PC_EX_MEM;
      hz.flush_if_id  = 1'b1;
      hz.flush_id_ex  = 1'b1;
      hz.flush_ex_mem = 1'b1;
      state_d         = IDLE;
      rem_d           = 2'd0;
    end else if (rule_ld_use) begin
      hz.enable_pc    = 1'b0;
      hz.enable_if_id = 1'b0;
      hz.flush_id_ex  = 1'b1;
      if (state_q == LD_STALL) begin
        rem_d = rem_q - 2'd1;
        if (rem_q == 2'd1) state_d = IDLE;
      end else if (LD_USE_STALLS > 1) begin
        // the detection cycle is the first bubble
        rem_d   = 2'(LD_USE_STALLS - 1);
        state_d = LD_STALL;
      end
    end else if ((hz.opcode_if_id == OP_J) || (hz.opcode_if_id == OP_JAL)) begin
      hz.pcsrc       = SEL_LOAD_JMP_ADDR;
      hz.flush_if_id = 1'b1;
    end else if ((hz.opcode_if_id == OP_RTYPE) && (hz.func_if_id == FUNC_JR)) begin
      hz.pcsrc       = SEL_LOAD_JR_ADDR;
      hz.flush_if_id = 1'b1;
    end else if ((hz.opcode_if_id == OP_BEQ) || (hz.opcode_if_id == OP_BNE)) begin
      hz.pcsrc       = SEL_LOAD_BR_ADDR;
      hz.flush_if_id = 1'b1;
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;
  logic [CNT_W-1:0] flush_cnt_q;

  // Counters saturate at all-ones rather than wrapping
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if ((rule_freeze || rule_ld_use) && (stall_cnt_q != '1))
        stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (rule_mispredict && (flush_cnt_q != '1))
        flush_cnt_q <= flush_cnt_q + CNT_W'(1);
    end
  end

  assign hz.stall_cnt = stall_cnt_q;
  assign hz.flush_cnt = flush_cnt_q;
`else
  assign hz.stall_cnt = CNT_W'(0);
  assign hz.flush_cnt = CNT_W'(0);
`endif

endmodule

// File: tb/tb_hazard_ctrl_gen2.sv
// tb_hazard_ctrl_gen2
//   Scoreboard bench: the driver applies one cycle of stimulus, evaluates a
//   behavioural model of the hazard rules and queues the expected outputs;
//   a monitor on the falling edge pops and compares against the DUT.
module tb_hazard_ctrl_gen2;

  localparam int N_STALL = 2;
  localparam int REG_AW  = 5;
  localparam int CNT_W   = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

`ifdef HAZARD_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  localparam logic [2:0] PC_NXT = 3'd0, PC_BR = 3'd1, PC_EXM = 3'd2,
                         PC_JMP = 3'd3, PC_JR = 3'd4;
  localparam logic [5:0] OP_RTYPE = 6'h00, OP_J = 6'h02, OP_JAL = 6'h03,
                         OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_LW = 6'h23,
                         OP_SW = 6'h2b, OP_ADDI = 6'h08;
  localparam logic [5:0] FN_JR = 6'h08, FN_ADD = 6'h20;

  logic CLK  = 1'b0;
  logic nRST = 1'b0;
  always #5 CLK = ~CLK;

  hazard_ctrl_gen2_if #(.REG_AW(REG_AW), .CNT_W(CNT_W)) hz ();

  hazard_ctrl_gen2 #(
    .LD_USE_STALLS(N_STALL),
    .REG_AW       (REG_AW),
    .CNT_W        (CNT_W)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .hz  (hz)
  );

  typedef struct {
    bit              ihit, dhit, ren, wen, halt_wb;
    logic [5:0]      op_if, func_if;
    logic [REG_AW-1:0] rs, rt, rt_ex;
    bit              dren_ex;
    logic [5:0]      op_ex;
    bit              zero;
  } stim_t;

  typedef struct {
    logic [2:0] pcsrc;
    logic [4:0] en;      // {pc, if_id, id_ex, ex_mem, mem_wb}
    logic [3:0] fl;      // {if_id, id_ex, ex_mem, mem_wb}
    logic       halted;
    int         scnt;
    int         fcnt;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  // model state: bubbles still owed, halt flag, event counters
  int stall_left = 0;
  bit m_halted   = 1'b0;
  int m_scnt     = 0;
  int m_fcnt     = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic stim_t idle_stim();
    stim_t s;
    s.ihit = 1'b1; s.dhit = 1'b1; s.ren = 1'b0; s.wen = 1'b0; s.halt_wb = 1'b0;
    s.op_if = OP_ADDI; s.func_if = 6'h00; s.rs = 5'd1; s.rt = 5'd2;
    s.rt_ex = 5'd3; s.dren_ex = 1'b0; s.op_ex = OP_ADDI; s.zero = 1'b0;
    return s;
  endfunction

  task automatic apply(input stim_t s);
    hz.ihit = s.ihit; hz.dhit = s.dhit; hz.dmemREN = s.ren; hz.dmemWEN = s.wen;
    hz.halt_wb = s.halt_wb; hz.opcode_if_id = s.op_if; hz.func_if_id = s.func_if;
    hz.rs_if_id = s.rs; hz.rt_if_id = s.rt; hz.rt_id_ex = s.rt_ex;
    hz.dren_id_ex = s.dren_ex; hz.opcode_ex_mem = s.op_ex; hz.zero_ex_mem = s.zero;
  endtask

  // One clock of stimulus: model the rules, queue the expectation, then
  // advance the model to what the following cycle will observe.
  task automatic step(input stim_t s);
    exp_t e;
    bit   mv, mp, lu;
    @(posedge CLK);
    #1;
    apply(s);
    mv = s.ihit && !((s.ren || s.wen) && !s.dhit) && !s.halt_wb;
    mp = (s.op_ex == OP_BEQ && !s.zero) || (s.op_ex == OP_BNE && s.zero);
    lu = s.dren_ex && s.rt_ex != 0 && (s.rt_ex == s.rs || s.rt_ex == s.rt);
    e.pcsrc = PC_NXT; e.en = {5{mv}}; e.fl = 4'b0000; e.halted = 1'b0;
    e.scnt = PERF ? m_scnt : 0;
    e.fcnt = PERF ? m_fcnt : 0;
    if (m_halted || s.halt_wb) begin
      e.en = 5'b00000; e.halted = 1'b1;
      m_halted = 1'b1;
    end else if (!mv) begin
      m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : m_scnt;
    end else if (mp) begin
      e.pcsrc = PC_EXM; e.fl = 4'b1110;
      stall_left = 0;
      m_fcnt = (m_fcnt < CNT_MAX) ? m_fcnt + 1 : m_fcnt;
    end else if (stall_left > 0 || lu) begin
      e.en = 5'b00111; e.fl = 4'b0100;
      if (stall_left == 0) stall_left = N_STALL;
      stall_left--;
      m_scnt = (m_scnt < CNT_MAX) ? m_scnt + 1 : m_scnt;
    end else if (s.op_if == OP_J || s.op_if == OP_JAL) begin
      e.pcsrc = PC_JMP; e.fl = 4'b1000;
    end else if (s.op_if == OP_RTYPE && s.func_if == FN_JR) begin
      e.pcsrc = PC_JR; e.fl = 4'b1000;
    end else if (s.op_if == OP_BEQ || s.op_if == OP_BNE) begin
      e.pcsrc = PC_BR; e.fl = 4'b1000;
    end
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    @(posedge CLK);
    #1;
    nRST = 1'b0;
    apply(idle_stim());
    stall_left = 0; m_halted = 1'b0; m_scnt = 0; m_fcnt = 0;
    @(negedge CLK);
    #2;
    nRST = 1'b1;
  endtask

  // monitor: compares whatever expectation is due this cycle
  initial begin
    exp_t e;
    forever begin
      @(negedge CLK);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("pcsrc",     32'(hz.pcsrc), 32'(e.pcsrc));
        check("enables",   32'({hz.enable_pc, hz.enable_if_id, hz.enable_id_ex,
                                hz.enable_ex_mem, hz.enable_mem_wb}), 32'(e.en));
        check("flushes",   32'({hz.flush_if_id, hz.flush_id_ex, hz.flush_ex_mem,
                                hz.flush_mem_wb}), 32'(e.fl));
        check("halted",    32'(hz.halted), 32'(e.halted));
        check("stall_cnt", 32'(hz.stall_cnt), 32'(e.scnt));
        check("flush_cnt", 32'(hz.flush_cnt), 32'(e.fcnt));
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 7))
      0: return OP_RTYPE;
      1: return OP_J;
      2: return OP_JAL;
      3: return OP_BEQ;
      4: return OP_BNE;
      5: return OP_LW;
      6: return OP_SW;
      default: return OP_ADDI;
    endcase
  endfunction

  initial begin
    stim_t s;
    apply(idle_stim());
    do_reset();

    // reset state, plain flow
    step(idle_stim());
    step(idle_stim());

    // load-use on rs: two bubbles, then normal flow
    s = idle_stim(); s.dren_ex = 1'b1; s.rt_ex = 5'd5; s.rs = 5'd5;
    step(s);
    step(idle_stim());
    step(idle_stim());

    // same load into $zero: no stall
    s.rt_ex = 5'd0; s.rs = 5'd0;
    step(s);

    // load-use on rt, freeze 3 cycles mid-stall, then finish the stall
    s = idle_stim(); s.dren_ex = 1'b1; s.rt_ex = 5'd7; s.rt = 5'd7;
    step(s);
    s = idle_stim(); s.ihit = 1'b0;
    repeat (3) step(s);
    s = idle_stim(); s.ren = 1'b1; s.dhit = 1'b0;
    step(s);
    step(idle_stim());
    step(idle_stim());

    // mispredict during LD_STALL aborts the stall
    s = idle_stim(); s.dren_ex = 1'b1; s.rt_ex = 5'd9; s.rs = 5'd9;
    step(s);
    s = idle_stim(); s.op_ex = OP_BEQ; s.zero = 1'b0;
    step(s);
    step(idle_stim());

    // mispredict and load-use together: mispredict wins, no stall afterwards
    s = idle_stim(); s.op_ex = OP_BNE; s.zero = 1'b1;
    s.dren_ex = 1'b1; s.rt_ex = 5'd4; s.rs = 5'd4;
    step(s);
    step(idle_stim());

    // jumps and predicted branches in IF/ID
    s = idle_stim(); s.op_if = OP_RTYPE; s.func_if = FN_JR;  step(s);
    s.func_if = FN_ADD;                                      step(s);
    s = idle_stim(); s.op_if = OP_J;                         step(s);
    s.op_if = OP_JAL;                                        step(s);
    s.op_if = OP_BEQ;                                        step(s);
    s.op_if = OP_BNE;                                        step(s);

    // 20 freeze cycles: stall_cnt saturates
    s = idle_stim(); s.ihit = 1'b0;
    repeat (20) step(s);

    // halt pulse: sticky until reset, then back to IDLE with counters cleared
    s = idle_stim(); s.halt_wb = 1'b1; s.op_ex = OP_BEQ;
    step(s);
    s = idle_stim(); s.op_if = OP_J;
    repeat (3) step(s);
    do_reset();
    step(idle_stim());

    // reset mid-stall leaves no residual bubble
    s = idle_stim(); s.dren_ex = 1'b1; s.rt_ex = 5'd6; s.rs = 5'd6;
    step(s);
    do_reset();
    step(idle_stim());

    // randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ((m_halted && $urandom_range(0, 7) == 0) || $urandom_range(0, 299) == 0)
        do_reset();
      s.ihit    = ($urandom_range(0, 9) != 0);
      s.ren     = ($urandom_range(0, 9) == 0);
      s.wen     = ($urandom_range(0, 9) == 0);
      s.dhit    = ($urandom_range(0, 2) != 0);
      s.halt_wb = ($urandom_range(0, 199) == 0);
      s.op_if   = pick_op();
      s.func_if = ($urandom_range(0, 2) == 0) ? FN_JR : FN_ADD;
      s.rs      = REG_AW'($urandom_range(0, 7));
      s.rt      = REG_AW'($urandom_range(0, 7));
      s.rt_ex   = REG_AW'($urandom_range(0, 7));
      s.dren_ex = ($urandom_range(0, 1) == 0);
      s.op_ex   = pick_op();
      s.zero    = ($urandom_range(0, 1) == 0);
      step(s);
    end

    @(negedge CLK);
    #1;
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl_gen2.md
# hazard_ctrl_gen2

Parametrised second-generation hazard controller for the 5-stage MIPS pipeline: IF/ID, ID/EX, EX/MEM and MEM/WB latch enables and flushes, plus the PC source select. Branches are predicted taken in IF/ID and resolved in EX/MEM; J, JAL and JR redirect from IF/ID. Adds a configurable multi-cycle load-use stall FSM, a sticky halt state, $zero-aware hazard detection, and optional saturating performance counters.

## Interface
Parameters:
- LD_USE_STALLS, 1, bubbles inserted per load-use hazard; legal range 1..3.
- REG_AW, 5, register index width.
- CNT_W, 32, performance counter width.

Ports:
- CLK  in  1  pipeline clock, rising edge.
- nRST  in  1  asynchronous, active-low reset.
- ihit, dhit  in  1 each  memory hit strobes.
- dmemREN, dmemWEN  in  1 each  data memory request currently outstanding.
- halt_wb  in  1  HALT opcode present in the WB stage.
- opcode_if_id, func_if_id  in  6 each  decode-stage instruction fields.
- rs_if_id, rt_if_id  in  REG_AW each  decode-stage source registers.
- rt_id_ex  in  REG_AW  execute-stage load destination.
- dren_id_ex  in  1  execute-stage instruction is a load.
- opcode_ex_mem  in  6  branch opcode being resolved.
- zero_ex_mem  in  1  ALU zero flag of the resolving branch.
- pcsrc  out  3  PC mux select; encodings are data_path_muxs_pkg SEL_LOAD_NXT_INSTR, SEL_LOAD_BR_ADDR, SEL_LOAD_NXT_PC_EX_MEM, SEL_LOAD_JMP_ADDR, SEL_LOAD_JR_ADDR.
- enable_pc, enable_if_id, enable_id_ex, enable_ex_mem, enable_mem_wb  out  1 each  latch enables.
- flush_if_id, flush_id_ex, flush_ex_mem, flush_mem_wb  out  1 each  synchronous latch clears.
- halted  out  1  sticky halt indicator.
- stall_cnt, flush_cnt  out  CNT_W each  performance counters.

## Operation
- move = ihit & !((dmemREN | dmemWEN) & !dhit) & !halt_wb.
- Default outputs: all enables = move; all flushes 0; pcsrc = NXT_INSTR.
- Decisions apply in priority order, first match wins; nothing below a matching rule applies.
- FSM states: IDLE, LD_STALL, HALTED.
- 1. HALTED, or halt_wb = 1: all enables 0, flushes 0, pcsrc NXT_INSTR, halted = 1. halt_wb moves the FSM to HALTED at the next edge. HALTED exits only on nRST.
- 2. move = 0: freeze. All enables 0, flushes 0. The FSM holds state and stall count.
- 3. Mispredict (opcode_ex_mem = BEQ & !zero_ex_mem, or BNE & zero_ex_mem): pcsrc NXT_PC_EX_MEM; flush IF/ID, ID/EX and EX/MEM. Aborts any load stall: the FSM goes to IDLE.
- 4. Load-use in IDLE (dren_id_ex & rt_id_ex != 0 & (rt_id_ex == rs_if_id | rt_id_ex == rt_if_id)), or FSM in LD_STALL:
  - enable_pc 0, enable_if_id 0, flush_id_ex 1, pcsrc NXT_INSTR.
  - On detection in IDLE with LD_USE_STALLS > 1: load the remaining counter with LD_USE_STALLS-1 and go to LD_STALL.
  - In LD_STALL, load-use detection is suppressed. The counter decrements on each moving cycle; when it reaches 0, go to IDLE.
- 5. opcode_if_id = J or JAL: pcsrc JMP_ADDR, flush_if_id.
- 6. RTYPE with func_if_id = JR: pcsrc JR_ADDR, flush_if_id.
- 7. opcode_if_id = BEQ or BNE: pcsrc BR_ADDR (predict taken), flush_if_id.
- flush_mem_wb is always 0; the port is reserved.

## Timing
- All outputs are combinational from the inputs and the registered state. The state and counters update on the CLK rising edge.
- Async reset: FSM IDLE, stall counter 0, halted 0, stall_cnt 0, flush_cnt 0.
- Output values while in reset are the IDLE values above.
- A load-use hazard costs exactly LD_USE_STALLS moving cycles. Freeze cycles during a stall do not count toward it.
- A mispredict costs 3 cycles; jumps and predicted branches cost 1.
- A mispredict and a load-use hazard in the same cycle: the mispredict wins, and no stall is started.
- halt_wb together with any other event: halt wins. No counter increments in that cycle.
- nRST deasserting mid-stall or while halted returns the block to IDLE with no residual stall.

## Configuration
- HAZARD_PERF_CNT_EN defined:
  - stall_cnt +1 per cycle with rule 2 or rule 4 active while not halted.
  - flush_cnt +1 per rule-3 cycle.
  - Both counters saturate at 2^CNT_W-1.
- Undefined: counter registers are not built; stall_cnt and flush_cnt are tied to 0.

## Test plan
- LD_USE_STALLS=2; load rt_id_ex=5 with rs_if_id=5 -> enable_pc=0 and flush_id_ex=1 for exactly 2 moving cycles, then IDLE; same stimulus with rt_id_ex=0 -> no stall.
- BEQ in EX/MEM with zero_ex_mem=0 during LD_STALL -> pcsrc=NXT_PC_EX_MEM, three flushes, FSM back to IDLE next edge, flush_cnt=1.
- ihit=0 for 3 cycles mid-stall -> all enables 0, stall counter unchanged, stall_cnt +3 (macro on).
- JR in IF/ID with ihit=1 -> pcsrc=JR_ADDR, flush_if_id=1; J in IF/ID -> JMP_ADDR.
- halt_wb pulse for 1 cycle -> halted=1 and all enables 0 until nRST low, then IDLE with counters 0.
- CNT_W=4 with 20 freeze cycles -> stall_cnt holds at 15; macro undefined -> counters read 0.
